bram_arbiter: RTL and testbench
===============================

// Module: bram_arbiter
// PURPOSE
//   Shares one single-port BRAM (en/we/addr/din, 1-cycle registered dout) between two requesters.
//   Each port uses a req/gnt handshake; one access is issued per cycle.
//   Round-robin arbitration by default.
//   Read data returns to the issuing port with a fixed 2-cycle latency from its grant.
// PARAMETERS
//   DATA_WIDTH  8   width of write data, read data and BRAM word
//   ADDR_WIDTH  12  BRAM address width (4096 words)
// PORTS
//   clk        in   1           single clock; all logic rising-edge
//   rst        in   1           synchronous, active-high reset
//   p0_req     in   1           port 0 access request; held until p0_gnt
//   p0_we      in   1           port 0 write (1) / read (0); valid with p0_req
//   p0_addr    in   ADDR_WIDTH  port 0 address
//   p0_wdata   in   DATA_WIDTH  port 0 write data
//   p0_gnt     out  1           port 0 request accepted this cycle (combinational)
//   p0_rvalid  out  1           port 0 read data valid (1-cycle pulse)
//   p0_rdata   out  DATA_WIDTH  port 0 read data; = mem_dout
//   p1_*       --   --          port 1, identical set to p0_*
//   mem_en     out  1           BRAM enable (registered)
//   mem_we     out  1           BRAM write enable (registered)
//   mem_addr   out  ADDR_WIDTH  BRAM address (registered)
//   mem_din    out  DATA_WIDTH  BRAM write data (registered)
//   mem_dout   in   DATA_WIDTH  BRAM registered read data
// BEHAVIOUR
// - Transfer on px_req & px_gnt in cycle N.
// - At the edge ending N, the command is registered onto mem_*: mem_en=1 and mem_we/addr/din copied in N+1.
// - BRAM captures dout at the end of N+1.
// - For reads only: px_rvalid=1 in N+2, with px_rdata=mem_dout.
// - Writes produce no rvalid.
// - gnt is combinational from req and the rr pointer; it is never asserted while rst=1.
//   - At most one gnt per cycle.
//   - Only one req: that port is granted.
//   - Both req: port = prio_ptr is granted.
// - prio_ptr (1 bit):
//   - reset 0.
//   - On any transfer, it becomes the index of the non-granted port.
//   - Unchanged when idle.
// - No req: mem_en=0 next cycle; mem_addr/din/we hold their last values (don't-care).
// - Throughput is 1 access/cycle, back-to-back, either port, no bubbles.
// - Read tag pipeline: 2 stages of {valid, port}. Stage 1 is loaded on a read transfer; stage 2 drives rvalid.
// - Ordering:
//   - Write to A in N, then read of A in N+1: returns the new data.
//   - Read and write to A in the same BRAM cycle is impossible (single command/cycle).
// - Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_din=0, p0/p1_rvalid=0, prio_ptr=0, tags cleared.
// - rst asserted mid-operation: in-flight reads are dropped (no rvalid), and no BRAM access is issued in the cycle after rst.
// - p0_rdata and p1_rdata are both driven from mem_dout at all times; consumers qualify with rvalid.
// - Requesters must keep req/we/addr/wdata stable until gnt.
// CONFIGURATION
//   BRAM_ARB_FIXED_PRIO_EN
//     defined:   port 0 always wins contention; prio_ptr removed; port 1 may starve.
//     undefined: round-robin as above; worst-case wait for a holding requester is 1 cycle.
// TESTING
// - Reset: rst=1 for 2 cycles with p0_req=p1_req=1 -> no gnt, mem_en=0, no rvalid; after release, p0 granted first.
// - Single write/read: p0 writes A=0x010, D=0xA5 in cycle N; p0 reads 0x010 in N+1
//   -> mem_en=1 in N+1 and N+2; p0_rvalid=1, p0_rdata=0xA5 in N+3; p1_rvalid stays 0.
// - Contention, both ports reading continuously (p0 addr 0x001=0x11, p1 addr 0x002=0x22)
//   -> gnt alternates p0,p1,p0,p1; rvalid alternates 2 cycles later with data 0x11/0x22; mem_en stays 1.
// - Mixed: p1 writes 0x0FF=0x3C while p0 reads 0x0FF in the next granted slot -> p0_rdata=0x3C; no rvalid for the write.
// - Reset mid-flight: p0 read granted in N, rst=1 in N+1 -> no p0_rvalid in N+2; prio_ptr=0 after reset.
// - With BRAM_ARB_FIXED_PRIO_EN: both req held for 4 cycles -> p0_gnt=1 all 4 cycles and p1_gnt=0; p1 is granted in the first cycle p0_req=0.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-port req/gnt arbiter sharing one single-port BRAM with a registered command stage.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority; round-robin otherwise.
module bram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    logic                  mem_en_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;
    logic                  tag1_v_q, tag2_v_q;
    port_e                 tag1_p_q, tag2_p_q;

    logic                  xfer;
    port_e                 sel;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_din;

`ifndef BRAM_ARB_FIXED_PRIO_EN
    port_e prio_q, prio_d;
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            p0_gnt = p0_req;
            p1_gnt = p1_req & ~p0_req;
`else
            if (p0_req && p1_req) begin
                if (prio_q == PORT0) p0_gnt = 1'b1;
                else                 p1_gnt = 1'b1;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
`endif
        end
    end

    always_comb begin
        xfer     = p0_gnt | p1_gnt;
        sel      = p1_gnt ? PORT1 : PORT0;
        cmd_we   = (sel == PORT1) ? p1_we    : p0_we;
        cmd_addr = (sel == PORT1) ? p1_addr  : p0_addr;
        cmd_din  = (sel == PORT1) ? p1_wdata : p0_wdata;
    end

`ifndef BRAM_ARB_FIXED_PRIO_EN
    // After any transfer the port that lost (or did not ask) gets priority next.
    always_comb begin
        prio_d = prio_q;
        if (xfer) prio_d = (sel == PORT1) ? PORT0 : PORT1;
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= PORT0;
        else     prio_q <= prio_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            tag1_v_q   <= 1'b0;
            tag1_p_q   <= PORT0;
            tag2_v_q   <= 1'b0;
            tag2_p_q   <= PORT0;
        end else begin
            mem_en_q <= xfer;
            if (xfer) begin
                mem_we_q   <= cmd_we;
                mem_addr_q <= cmd_addr;
                mem_din_q  <= cmd_din;
            end
            tag1_v_q <= xfer & ~cmd_we;
            tag1_p_q <= sel;
            tag2_v_q <= tag1_v_q;
            tag2_p_q <= tag1_p_q;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign p0_rvalid = tag2_v_q & (tag2_p_q == PORT0);
    assign p1_rvalid = tag2_v_q & (tag2_p_q == PORT1);
    assign p0_rdata  = mem_dout;
    assign p1_rdata  = mem_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_bram_arbiter;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        mem_dout <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and apply the request inputs for it.
    task automatic cyc(input logic r, input logic q0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic q1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        rst = r;
        p0_req = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = q1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 0, 12'h000, 8'h00, 1, 0, 12'h000, 8'h00);
            chk("rst_p0_gnt", p0_gnt, 0);
            chk("rst_p1_gnt", p1_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_p0_rvalid", p0_rvalid, 0);
            chk("rst_p1_rvalid", p1_rvalid, 0);
        end

`ifndef BRAM_ARB_FIXED_PRIO_EN
        // A: both write, p0 wins after reset
        cyc(0, 1, 1, 12'h001, 8'h11, 1, 1, 12'h002, 8'h22);
        chk("A_p0_gnt", p0_gnt, 1);
        chk("A_p1_gnt", p1_gnt, 0);
        chk("A_mem_en", mem_en, 0);
        // B: p1 alone
        cyc(0, 0, 0, 12'h000, 8'h00, 1, 1, 12'h002, 8'h22);
        chk("B_p1_gnt", p1_gnt, 1);
        chk("B_mem_en", mem_en, 1);
        chk("B_mem_we", mem_we, 1);
        chk("B_mem_addr", mem_addr, 12'h001);
        chk("B_mem_din", mem_din, 8'h11);
        // C: p0 writes 0x010=A5
        cyc(0, 1, 1, 12'h010, 8'hA5, 0, 0, 12'h000, 8'h00);
        chk("C_p0_gnt", p0_gnt, 1);
        chk("C_mem_addr", mem_addr, 12'h002);
        chk("C_mem_din", mem_din, 8'h22);
        // D: p0 reads 0x010
        cyc(0, 1, 0, 12'h010, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("D_p0_gnt", p0_gnt, 1);
        chk("D_mem_en", mem_en, 1);
        chk("D_mem_we", mem_we, 1);
        chk("D_mem_addr", mem_addr, 12'h010);
        chk("D_mem_din", mem_din, 8'hA5);
        cyc(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("E_mem_en", mem_en, 1);
        chk("E_mem_we", mem_we, 0);
        chk("E_p0_rvalid", p0_rvalid, 0);
        cyc(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("F_p0_rvalid", p0_rvalid, 1);
        chk("F_p0_rdata", p0_rdata, 8'hA5);
        chk("F_p1_rvalid", p1_rvalid, 0);
        chk("F_mem_en", mem_en, 0);

        // Contention reads; prio points at p1 after D
        cyc(0, 1, 0, 12'h001, 8'h00, 1, 0, 12'h002, 8'h00);
        chk("G_p1_gnt", p1_gnt, 1);
        chk("G_p0_gnt", p0_gnt, 0);
        cyc(0, 1, 0, 12'h001, 8'h00, 1, 0, 12'h002, 8'h00);
        chk("H_p0_gnt", p0_gnt, 1);
        chk("H_p1_gnt", p1_gnt, 0);
        chk("H_mem_addr", mem_addr, 12'h002);
        cyc(0, 1, 0, 12'h001, 8'h00, 1, 0, 12'h002, 8'h00);
        chk("I_p1_gnt", p1_gnt, 1);
        chk("I_p1_rvalid", p1_rvalid, 1);
        chk("I_p1_rdata", p1_rdata, 8'h22);
        chk("I_p0_rvalid", p0_rvalid, 0);
        chk("I_mem_addr", mem_addr, 12'h001);
        cyc(0, 1, 0, 12'h001, 8'h00, 1, 0, 12'h002, 8'h00);
        chk("J_p0_gnt", p0_gnt, 1);
        chk("J_p0_rvalid", p0_rvalid, 1);
        chk("J_p0_rdata", p0_rdata, 8'h11);
        chk("J_mem_en", mem_en, 1);
        cyc(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("K_p1_rvalid", p1_rvalid, 1);
        chk("K_p1_rdata", p1_rdata, 8'h22);
        chk("K_mem_en", mem_en, 1);
        cyc(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("L_p0_rvalid", p0_rvalid, 1);
        chk("L_p0_rdata", p0_rdata, 8'h11);
        chk("L_mem_en", mem_en, 0);

        // Mixed: p1 writes 0x0FF=3C first (prio=p1), p0 read follows
        cyc(0, 1, 0, 12'h0FF, 8'h00, 1, 1, 12'h0FF, 8'h3C);
        chk("M_p1_gnt", p1_gnt, 1);
        chk("M_p0_gnt", p0_gnt, 0);
        cyc(0, 1, 0, 12'h0FF, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("N_p0_gnt", p0_gnt, 1);
        chk("N_mem_we", mem_we, 1);
        cyc(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("O_p0_rvalid", p0_rvalid, 0);
        chk("O_p1_rvalid", p1_rvalid, 0);
        chk("O_mem_addr", mem_addr, 12'h0FF);
        cyc(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("P_p0_rvalid", p0_rvalid, 1);
        chk("P_p0_rdata", p0_rdata, 8'h3C);
        chk("P_p1_rvalid", p1_rvalid, 0);

        // Reset mid-flight: prio is p1 here, p0 read alone still granted
        cyc(0, 1, 0, 12'h001, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("Q_p0_gnt", p0_gnt, 1);
        cyc(1, 1, 0, 12'h001, 8'h00, 1, 0, 12'h002, 8'h00);
        chk("R_p0_gnt", p0_gnt, 0);
        chk("R_p1_gnt", p1_gnt, 0);
        cyc(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        chk("S_p0_rvalid", p0_rvalid, 0);
        chk("S_mem_en", mem_en, 0);
        cyc(0, 1, 0, 12'h001, 8'h00, 1, 0, 12'h002, 8'h00);
        chk("T_p0_gnt", p0_gnt, 1);
        chk("T_p1_gnt", p1_gnt, 0);
        chk("T_p1_rvalid", p1_rvalid, 0);
`else
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 12'h001, 8'h00, 1, 0, 12'h002, 8'h00);
            chk("FP_p0_gnt", p0_gnt, 1);
            chk("FP_p1_gnt", p1_gnt, 0);
        end
        cyc(0, 0, 0, 12'h000, 8'h00, 1, 0, 12'h002, 8'h00);
        chk("FP_p1_gnt_free", p1_gnt, 1);
        chk("FP_p0_gnt_free", p0_gnt, 0);
        chk("FP_mem_addr", mem_addr, 12'h001);
`endif

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
